// File: rtl/spi_note_dispatcher.sv
// spi_note_dispatcher: SPI note-command receiver, voice allocator and paced ADSR key-state update queue.
module spi_note_dispatcher #(
    parameter int NUM_VOICES = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_sck,
    input  logic                  i_mosi,
    input  logic                  i_cs_n,
    input  logic [1:0]            i_pipeline_state,
    output logic                  o_SPI_flag,
    output logic                  o_SPI_note_status,
    output logic [7:0]            o_SPI_voice_index,
    output logic [NUM_VOICES-1:0] o_voice_active,
    output logic                  o_drop
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [2:0]  sck_s;
    logic [1:0]  mosi_s, cs_s;
    logic [4:0]  bit_cnt;
    logic [23:0] shift;
    logic        frame_valid, sck_rise;
    logic [NUM_VOICES-1:0] active;
    logic [6:0]  notes [NUM_VOICES];
    logic [8:0]  mem [FIFO_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;
    logic        full, empty, issue, armed;
    logic        is_on, is_off, hit, free, want_push, push, alloc, rel;
    logic [7:0]  hit_idx, free_idx;
    logic [8:0]  push_data, head;

    assign sck_rise = sck_s[1] & ~sck_s[2];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sck_s       <= '0;
            mosi_s      <= '0;
            cs_s        <= 2'b11;
            bit_cnt     <= '0;
            shift       <= '0;
            frame_valid <= 1'b0;
        end else begin
            sck_s       <= {sck_s[1:0], i_sck};
            mosi_s      <= {mosi_s[0], i_mosi};
            cs_s        <= {cs_s[0], i_cs_n};
            frame_valid <= 1'b0;
            if (cs_s[1])
                bit_cnt <= '0;
            else if (sck_rise) begin
                shift       <= {shift[22:0], mosi_s[1]};
                bit_cnt     <= (bit_cnt == 5'd23) ? 5'd0 : bit_cnt + 5'd1;
                frame_valid <= (bit_cnt == 5'd23);
            end
        end
    end

    // Descending scan so the lowest matching / free voice wins.
    always_comb begin
        hit      = 1'b0;
        free     = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (active[i] && notes[i] == shift[14:8]) begin
                hit     = 1'b1;
                hit_idx = 8'(i);
            end
            if (!active[i]) begin
                free     = 1'b1;
                free_idx = 8'(i);
            end
        end
    end

    assign is_on     = frame_valid && !shift[15] && shift[23:20] == 4'h9 && shift[7:0] != 8'd0;
    assign is_off    = frame_valid && !shift[15] && (shift[23:20] == 4'h8 || (shift[23:20] == 4'h9 && shift[7:0] == 8'd0));
    assign want_push = (is_on && (hit || free)) || (is_off && hit);
    assign full      = (wr_ptr ^ rd_ptr) == {1'b1, {PW{1'b0}}};
    assign empty     = wr_ptr == rd_ptr;
    assign push      = want_push && !full;
    assign alloc     = push && is_on && !hit;
    assign rel       = push && is_off;
    assign push_data = {is_on, (is_on && !hit) ? free_idx : hit_idx};
    assign o_drop    = (is_on && !hit && !free) || (want_push && full);
    assign head      = mem[rd_ptr[PW-1:0]];
    assign issue     = !empty && armed && i_pipeline_state == 2'd0;
    assign o_voice_active = active;

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr[PW-1:0]] <= push_data;
        for (int i = 0; i < NUM_VOICES; i++)
            if (alloc && 8'(i) == push_data[7:0])
                notes[i] <= shift[14:8];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            armed             <= 1'b1;
            active            <= '0;
            o_SPI_flag        <= 1'b0;
            o_SPI_note_status <= 1'b0;
            o_SPI_voice_index <= '0;
        end else begin
            wr_ptr     <= wr_ptr + {{PW{1'b0}}, push};
            rd_ptr     <= rd_ptr + {{PW{1'b0}}, issue};
            armed      <= issue ? 1'b0 : (i_pipeline_state == 2'd2) ? 1'b1 : armed;
            o_SPI_flag <= issue;
            if (issue)
                {o_SPI_note_status, o_SPI_voice_index} <= head;
            for (int i = 0; i < NUM_VOICES; i++)
                if ((alloc || rel) && 8'(i) == push_data[7:0])
                    active[i] <= alloc;
        end
    end
endmodule

// File: tb/tb_spi_note_dispatcher.sv
// tb_spi_note_dispatcher: directed scenarios for SPI capture, voice allocation, queueing and pacing.
module tb_spi_note_dispatcher;
    logic       clk = 0, rst = 1, sck = 0, mosi = 0, cs_n = 1, cycling = 0;
    logic [1:0] ps = 0;
    logic       flag, status, drop;
    logic [7:0] idx, active;
    int         checks = 0, failures = 0, drops = 0, sep_err = 0;
    bit         saw2 = 0, have_prev = 0;
    logic [8:0] fq[$];

    spi_note_dispatcher #(.NUM_VOICES(8), .FIFO_DEPTH(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_sck(sck), .i_mosi(mosi), .i_cs_n(cs_n),
        .i_pipeline_state(ps), .o_SPI_flag(flag), .o_SPI_note_status(status),
        .o_SPI_voice_index(idx), .o_voice_active(active), .o_drop(drop)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1 ps = cycling ? ((ps == 2'd2) ? 2'd0 : ps + 2'd1) : 2'd0;
    end

    // Record flags and drops; flag a separation error when two flags lack a state-2 cycle between them.
    initial forever begin
        @(negedge clk);
        if (flag) begin
            if (have_prev && !saw2) sep_err++;
            have_prev = 1;
            saw2 = 0;
            fq.push_back({status, idx});
        end
        if (ps == 2'd2) saw2 = 1;
        if (drop) drops++;
    end

    function automatic logic [8:0] get(int k);
        return (k < fq.size()) ? fq[k] : 9'bx;
    endfunction

    task automatic spi_bits(input logic [23:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = d[i];
            #40 sck = 1;
            #40 sck = 0;
        end
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        cs_n = 0;
        #40;
        spi_bits({a, b, c}, 24);
        #40 cs_n = 1;
        #80;
    endtask

    task automatic wait_flags(input int n);
        for (int i = 0; i < 300 && fq.size() < n; i++) @(posedge clk);
        repeat (20) @(posedge clk);
    endtask

    task automatic do_reset();
        cs_n = 1;
        sck = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        fq.delete();
        drops = 0;
        sep_err = 0;
        have_prev = 0;
        saw2 = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (flag !== 1'b0) begin failures++; $display("FAIL reset_flag: got %b expected 0", flag); end
        checks++; if (status !== 1'b0) begin failures++; $display("FAIL reset_status: got %b expected 0", status); end
        checks++; if (idx !== 8'h00) begin failures++; $display("FAIL reset_index: got %h expected 00", idx); end
        checks++; if (active !== 8'h00) begin failures++; $display("FAIL reset_active: got %h expected 00", active); end
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL reset_drop: got %b expected 0", drop); end
    endtask

    task automatic test_basic();
        cycling = 1;
        frame(8'h90, 8'h3C, 8'h64);
        wait_flags(1);
        checks++; if (fq.size() != 1) begin failures++; $display("FAIL basic_count1: got %0d expected 1", fq.size()); end
        checks++; if (get(0) !== 9'h100) begin failures++; $display("FAIL basic_on0: got %h expected 100", get(0)); end
        checks++; if (active !== 8'h01) begin failures++; $display("FAIL basic_active1: got %h expected 01", active); end
        frame(8'h91, 8'h40, 8'h10);
        frame(8'h80, 8'h3C, 8'h00);
        wait_flags(3);
        checks++; if (fq.size() != 3) begin failures++; $display("FAIL basic_count3: got %0d expected 3", fq.size()); end
        checks++; if (get(1) !== 9'h101) begin failures++; $display("FAIL basic_on1: got %h expected 101", get(1)); end
        checks++; if (get(2) !== 9'h000) begin failures++; $display("FAIL basic_off0: got %h expected 000", get(2)); end
        checks++; if (active !== 8'h02) begin failures++; $display("FAIL basic_active2: got %h expected 02", active); end
        checks++; if (sep_err != 0) begin failures++; $display("FAIL basic_sep: got %0d expected 0", sep_err); end
    endtask

    task automatic test_voices();
        do_reset();
        cycling = 1;
        for (int i = 0; i < 9; i++) frame(8'h90, 8'h20 + 8'(i), 8'h40);
        wait_flags(8);
        checks++; if (fq.size() != 8) begin failures++; $display("FAIL voices_count: got %0d expected 8", fq.size()); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (get(k) !== (9'h100 | 9'(k))) begin failures++; $display("FAIL voices_alloc%0d: got %h expected %h", k, get(k), 9'h100 | 9'(k)); end
        end
        checks++; if (drops != 1) begin failures++; $display("FAIL voices_drop: got %0d expected 1", drops); end
        checks++; if (active !== 8'hFF) begin failures++; $display("FAIL voices_full: got %h expected ff", active); end
        frame(8'h90, 8'h23, 8'h00);
        wait_flags(9);
        checks++; if (get(8) !== 9'h003) begin failures++; $display("FAIL voices_vel0off: got %h expected 003", get(8)); end
        checks++; if (active !== 8'hF7) begin failures++; $display("FAIL voices_active_f7: got %h expected f7", active); end
        frame(8'h90, 8'h50, 8'h7F);
        wait_flags(10);
        checks++; if (get(9) !== 9'h103) begin failures++; $display("FAIL voices_reuse3: got %h expected 103", get(9)); end
        checks++; if (active !== 8'hFF) begin failures++; $display("FAIL voices_refill: got %h expected ff", active); end
    endtask

    task automatic test_stall();
        cycling = 0;
        do_reset();
        frame(8'h90, 8'h10, 8'h40);
        wait_flags(1);
        for (int i = 1; i <= 5; i++) frame(8'h90, 8'h10 + 8'(i), 8'h40);
        repeat (20) @(posedge clk);
        checks++; if (fq.size() != 1) begin failures++; $display("FAIL stall_hold: got %0d expected 1", fq.size()); end
        checks++; if (drops != 1) begin failures++; $display("FAIL stall_fifo_drop: got %0d expected 1", drops); end
        checks++; if (active !== 8'h1F) begin failures++; $display("FAIL stall_active: got %h expected 1f", active); end
        cycling = 1;
        wait_flags(5);
        checks++; if (fq.size() != 5) begin failures++; $display("FAIL stall_drain: got %0d expected 5", fq.size()); end
        for (int k = 1; k <= 4; k++) begin
            checks++; if (get(k) !== (9'h100 | 9'(k))) begin failures++; $display("FAIL stall_order%0d: got %h expected %h", k, get(k), 9'h100 | 9'(k)); end
        end
        checks++; if (sep_err != 0) begin failures++; $display("FAIL stall_sep: got %0d expected 0", sep_err); end
    endtask

    task automatic test_partial();
        do_reset();
        cycling = 1;
        cs_n = 0;
        #40;
        spi_bits(24'h000903, 12);
        #40 cs_n = 1;
        #80;
        frame(8'h90, 8'h30, 8'h7F);
        wait_flags(1);
        repeat (30) @(posedge clk);
        checks++; if (fq.size() != 1) begin failures++; $display("FAIL partial_count: got %0d expected 1", fq.size()); end
        checks++; if (get(0) !== 9'h100) begin failures++; $display("FAIL partial_entry: got %h expected 100", get(0)); end
        checks++; if (active !== 8'h01) begin failures++; $display("FAIL partial_active: got %h expected 01", active); end
        checks++; if (drops != 0) begin failures++; $display("FAIL partial_drop: got %0d expected 0", drops); end
    endtask

    task automatic test_reset_mid();
        cycling = 0;
        do_reset();
        frame(8'h90, 8'h11, 8'h40);
        frame(8'h90, 8'h12, 8'h40);
        frame(8'h90, 8'h13, 8'h40);
        repeat (20) @(posedge clk);
        checks++; if (status !== 1'b1) begin failures++; $display("FAIL midrst_pre_status: got %b expected 1", status); end
        cs_n = 0;
        #40;
        spi_bits(24'h000ABC, 12);
        @(posedge clk);
        #2 rst = 1;
        @(negedge clk);
        checks++; if ({flag, status, idx, drop} !== 11'h000) begin failures++; $display("FAIL midrst_outputs: got %h expected 000", {flag, status, idx, drop}); end
        checks++; if (active !== 8'h00) begin failures++; $display("FAIL midrst_active: got %h expected 00", active); end
        @(posedge clk);
        #1 rst = 0;
        fq.delete();
        have_prev = 0;
        spi_bits(24'h000DEF, 12);
        #40 cs_n = 1;
        cycling = 1;
        repeat (100) @(posedge clk);
        checks++; if (fq.size() != 0) begin failures++; $display("FAIL midrst_noflag: got %0d expected 0", fq.size()); end
        checks++; if (active !== 8'h00) begin failures++; $display("FAIL midrst_active_after: got %h expected 00", active); end
        frame(8'h90, 8'h30, 8'h7F);
        wait_flags(1);
        checks++; if (fq.size() != 1) begin failures++; $display("FAIL midrst_new_count: got %0d expected 1", fq.size()); end
        checks++; if (get(0) !== 9'h100) begin failures++; $display("FAIL midrst_new_entry: got %h expected 100", get(0)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_voices();
        test_stall();
        test_partial();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_note_dispatcher.md
# spi_note_dispatcher

Front-end SPI slave that receives MIDI-style note commands from the host, allocates synthesizer voices, and drives the ADSR key-state update port (`SPI_flag` / `SPI_note_status` / `SPI_voice_index`). Commands are queued and released at most one per voice-pipeline round, so the ADSR's single-entry update buffer never overruns. Sits between the external SPI pins and every per-voice block that consumes key-state updates.

## Interface
- `NUM_VOICES`, 8, number of allocatable voices (1..256); voice indices are 0..NUM_VOICES-1.
- `FIFO_DEPTH`, 4, update queue depth (power of 2, ≥2).

- `i_clk`  in  1  system clock.
- `i_reset`  in  1  reset; one clock, asynchronous and active-high.
- `i_sck`  in  1  SPI clock, asynchronous to `i_clk`, mode 0.
- `i_mosi`  in  1  SPI data, MSB first.
- `i_cs_n`  in  1  SPI chip select, active low.
- `i_pipeline_state`  in  2  voice pipeline phase (0 read, 1 compute, 2 update).
- `o_SPI_flag`  out  1  one-cycle update strobe to ADSR.
- `o_SPI_note_status`  out  1  1 = key down, 0 = key up; valid with flag.
- `o_SPI_voice_index`  out  8  target voice; valid with flag.
- `o_voice_active`  out  NUM_VOICES  per-voice allocation bit.
- `o_drop`  out  1  one-cycle pulse: command discarded (no free voice or FIFO full).

## Operation
- SPI capture: `i_sck`, `i_mosi`, `i_cs_n` each pass a 2-flop synchronizer. MOSI sampled on detected SCK rising edge while synchronized CS low. Bit counter 0..23; byte0 status, byte1 note, byte2 velocity. Counter wraps after 24 bits, so back-to-back frames within one CS low are accepted. CS high clears counter; partial frame discarded silently.
- Decode on frame completion:
  - status[7:4]=0x9, velocity≠0: NOTE_ON. status[7:4]=0x9, velocity=0, or 0x8: NOTE_OFF. Channel nibble ignored.
  - Any other status, or note[7]=1: ignored (no table change, no drop).
- Voice table: per voice `active` bit and 7-bit note.
  - NOTE_ON, note already active in voice v: enqueue {1, v} (retrigger), table unchanged.
  - NOTE_ON, new note: lowest-index inactive voice v; set active, store note, enqueue {1, v}. No inactive voice: `o_drop` pulse, nothing enqueued.
  - NOTE_OFF, note active in voice v: clear active, enqueue {0, v}. Not found: ignored.
  - FIFO full at decode: `o_drop` pulse, table unchanged, nothing enqueued.
- Release pacing: `armed` register, 1 at reset. Set on any cycle with `i_pipeline_state`==2; cleared when an entry is issued. Issue when FIFO non-empty, `armed`=1, `i_pipeline_state`==0, and this is not the cycle on which `armed` is being set. Issue = pop head, `o_SPI_flag`=1 for exactly one cycle with status/index from the popped entry.
- Voice index zero-extended to 8 bits.

## Timing
- Reset values: `o_SPI_flag`=0, `o_SPI_note_status`=0, `o_SPI_voice_index`=0, `o_voice_active`=0, `o_drop`=0; FIFO empty, bit counter 0, `armed`=1. Reset mid-frame discards the frame; mid-queue discards all entries.
- Decode/allocate occurs the `i_clk` cycle after the 24th synchronized SCK rising edge; FIFO write and `o_voice_active` update on that same edge; `o_drop` pulses on that cycle.
- Earliest issue: first `i_pipeline_state`==0 cycle after the FIFO write is visible (≥1 cycle after write).
- At most one issue between consecutive `i_pipeline_state`==2 cycles; ≥1 state-2 cycle always separates two flags.
- Simultaneous FIFO write and pop: both happen; full flag evaluated before the pop (write when full still drops).
- `o_SPI_note_status`/`o_SPI_voice_index` hold last issued value between flags.
- SCK must be ≤ `i_clk`/4.

## Test plan
- Reset, frame 0x90,0x3C,0x64 -> one flag, status=1, index=0; `o_voice_active`=0x01.
- Then 0x91,0x40,0x10 and 0x80,0x3C,0x00 -> flags {1,1} then {0,0}, separated by a state-2 cycle; `o_voice_active`=0x02.
- NOTE_ON 9 distinct notes, NUM_VOICES=8 -> indices 0..7 issued, 9th pulses `o_drop`; 0x90,note,0x00 for voice 3's note -> {0,3}; next new NOTE_ON gets voice 3.
- Hold `i_pipeline_state`=0 (no state 2) after one issue, send 5 commands -> no further flags, 5th drops; resume cycling -> 4 flags in FIFO order.
- Deassert CS after 12 bits, then full frame 0x90,0x30,0x7F -> only one flag {1,0}.
- Assert `i_reset` with 2 entries queued and mid-frame -> all outputs at reset values next cycle; no flags until a new complete frame.
